// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4, branch/jump redirect, IF/ID register,
// and a one-entry skid buffer that keeps a word returned during a decode stall.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        jump,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] out_pc_added,
  output logic [31:0] out_instruction,
  output logic        out_valid
);

  typedef enum logic {
    RUN  = 1'b0,
    HELD = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc_p0;
  logic [31:0] skid_p0;
  logic [31:0] ifid_pc_added_p1;
  logic [31:0] ifid_instr_p1;
  logic        vld_p1;

  logic        jump_take;
  logic        avail;
  logic [31:0] word;
  logic [31:0] jump_target;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  // Pseudo-direct jump: top nibble of the delay-slot PC, 26-bit word index.
  function automatic logic [31:0] jump_dest(input logic [3:0] pc_hi, input logic [25:0] index);
    return {pc_hi, index, 2'b00};
  endfunction

  always_comb begin
    jump_take   = jump & vld_p1 & ~stall;
    jump_target = jump_dest(ifid_pc_added_p1[31:28], ifid_instr_p1[25:0]);
    avail       = (state == HELD) | imem_ready;
    word        = (state == HELD) ? skid_p0 : imem_rdata;
  end

  // A HELD word already belongs to the current PC, so no new request is issued.
  assign imem_req        = ~rst & (state == RUN);
  assign imem_addr       = pc_p0;
  assign out_pc_added    = ifid_pc_added_p1;
  assign out_instruction = ifid_instr_p1;
  assign out_valid       = vld_p1;

  // ---- PC / skid (p0) -> IF/ID (p1) ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= RUN;
      pc_p0            <= RESET_PC;
      skid_p0          <= 32'h0;
      ifid_pc_added_p1 <= 32'h0;
      ifid_instr_p1    <= NOP;
      vld_p1           <= 1'b0;
    end else if (redirect) begin
      state            <= RUN;
      pc_p0            <= redirect_pc;
      skid_p0          <= 32'h0;
      ifid_pc_added_p1 <= 32'h0;
      ifid_instr_p1    <= NOP;
      vld_p1           <= 1'b0;
    end else if (stall) begin
      if (state == RUN && imem_ready) begin
        skid_p0 <= imem_rdata;
        state   <= HELD;
      end
    end else if (jump_take) begin
      state            <= RUN;
      pc_p0            <= jump_target;
      skid_p0          <= 32'h0;
      ifid_pc_added_p1 <= 32'h0;
      ifid_instr_p1    <= NOP;
      vld_p1           <= 1'b0;
    end else if (avail) begin
      state            <= RUN;
      pc_p0            <= pc_inc(pc_p0);
      ifid_pc_added_p1 <= pc_inc(pc_p0);
      ifid_instr_p1    <= word;
      vld_p1           <= 1'b1;
    end else begin
      ifid_pc_added_p1 <= 32'h0;
      ifid_instr_p1    <= NOP;
      vld_p1           <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan steps followed by random traffic,
// every edge compared against a rule-level reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        jump;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] out_pc_added;
  logic [31:0] out_instruction;
  logic        out_valid;

  logic [31:0] patch_addr = 32'h0000_0FFF;
  logic [31:0] patch_data = 32'h0;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [31:0] m_pc, m_hword, m_opa, m_oin;
  bit          m_held, m_ov;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .jump(jump), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .out_pc_added(out_pc_added), .out_instruction(out_instruction),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == patch_addr) ? patch_data : 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_rdata = (imem_addr == patch_addr) ? patch_data : 32'h1000_0000 + (imem_addr >> 2);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_hword = 32'h0; m_opa = 32'h0; m_oin = 32'h0;
    m_held = 0; m_ov = 0;
  endtask

  task automatic check_all();
    check("imem_addr", imem_addr, m_pc);
    check("imem_req", 32'(imem_req), 32'(!m_held));
    check("out_pc_added", out_pc_added, m_opa);
    check("out_instruction", out_instruction, m_oin);
    check("out_valid", 32'(out_valid), 32'(m_ov));
  endtask

  // Apply the per-edge rules to the model using the inputs as they stand now.
  task automatic step();
    logic [31:0] n_pc, n_hword, n_opa, n_oin, tgt;
    bit n_held, n_ov, jt;
    n_pc = m_pc; n_hword = m_hword; n_held = m_held;
    n_opa = m_opa; n_oin = m_oin; n_ov = m_ov;
    jt  = jump && m_ov && !stall;
    tgt = {m_opa[31:28], m_oin[25:0], 2'b00};
    if (redirect) begin
      n_pc = redirect_pc; n_held = 0; n_opa = 0; n_oin = 0; n_ov = 0;
    end else if (stall) begin
      if (!m_held && imem_ready) begin
        n_held = 1; n_hword = mem_word(m_pc);
      end
    end else if (jt) begin
      n_pc = tgt; n_held = 0; n_opa = 0; n_oin = 0; n_ov = 0;
    end else if (m_held || imem_ready) begin
      n_opa = m_pc + 32'd4;
      n_oin = m_held ? m_hword : mem_word(m_pc);
      n_ov  = 1;
      n_pc  = m_pc + 32'd4;
      n_held = 0;
    end else begin
      n_opa = 0; n_oin = 0; n_ov = 0;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_hword = n_hword; m_held = n_held;
    m_opa = n_opa; m_oin = n_oin; m_ov = n_ov;
    check_all();
  endtask

  initial begin
    rst = 1'b1; stall = 0; redirect = 0; redirect_pc = 0; jump = 0; imem_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", 32'(imem_req), 32'h0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_instr", out_instruction, 32'h0);
    check("rst_pc_added", out_pc_added, 32'h0);
    rst = 1'b0;
    #1;
    check("req_after_rst", 32'(imem_req), 32'h1);

    // Zero-wait streaming
    imem_ready = 1;
    step();
    check("stream0_instr", out_instruction, 32'h1000_0000);
    check("stream0_pc", out_pc_added, 32'd4);
    step();
    check("stream1_instr", out_instruction, 32'h1000_0001);
    check("stream1_pc", out_pc_added, 32'd8);

    // Two wait states at PC 8
    imem_ready = 0;
    step();
    check("wait1_valid", 32'(out_valid), 32'h0);
    check("wait1_addr", imem_addr, 32'd8);
    step();
    check("wait2_valid", 32'(out_valid), 32'h0);
    imem_ready = 1;
    step();
    check("after_wait_instr", out_instruction, 32'h1000_0002);
    check("after_wait_pc", out_pc_added, 32'd12);
    step();

    // Stall three edges with ready at PC 16
    stall = 1;
    step();
    check("stall_req", 32'(imem_req), 32'h0);
    check("stall_frozen", out_instruction, 32'h1000_0003);
    step();
    step();
    stall = 0;
    step();
    check("skid_issue_instr", out_instruction, 32'h1000_0004);
    check("skid_issue_pc", out_pc_added, 32'd20);
    check("skid_issue_addr", imem_addr, 32'd20);
    step();

    // Jump from IF/ID: pc_added 0x10, target field 0x40
    patch_addr = 32'h0000_000C;
    patch_data = 32'h0800_0040;
    redirect = 1; redirect_pc = 32'h0000_000C;
    step();
    redirect = 0;
    step();
    check("jmp_slot_pc", out_pc_added, 32'h10);
    check("jmp_slot_instr", out_instruction, 32'h0800_0040);
    jump = 1;
    step();
    jump = 0;
    check("jmp_bubble", 32'(out_valid), 32'h0);
    check("jmp_target", imem_addr, 32'h100);
    step();
    check("jmp_fetch", out_instruction, 32'h1000_0040);

    // Redirect beats stall and jump while HELD
    stall = 1;
    step();
    check("held_req", 32'(imem_req), 32'h0);
    redirect = 1; redirect_pc = 32'h200; jump = 1;
    step();
    redirect = 0; stall = 0; jump = 0;
    check("redir_addr", imem_addr, 32'h200);
    check("redir_valid", 32'(out_valid), 32'h0);
    check("redir_run", 32'(imem_req), 32'h1);
    step();
    check("redir_fetch", out_instruction, 32'h1000_0080);

    // PC wrap and unaligned redirect
    redirect = 1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 0;
    step();
    check("wrap_pc_added", out_pc_added, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);
    redirect = 1; redirect_pc = 32'h0000_0203;
    step();
    redirect = 0;
    step();
    check("unaligned_pc_added", out_pc_added, 32'h207);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      stall       = ($urandom % 4) == 0;
      imem_ready  = ($urandom % 3) != 0;
      jump        = ($urandom % 5) == 0;
      redirect    = ($urandom % 12) == 0;
      redirect_pc = (($urandom % 8) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      step();
    end

    // Asynchronous reset while HELD
    stall = 1; imem_ready = 1; redirect = 0; jump = 0;
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    check("arst_req", 32'(imem_req), 32'h0);
    check("arst_addr", imem_addr, 32'h0);
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_instr", out_instruction, 32'h0);
    check("arst_pc_added", out_pc_added, 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0; stall = 0; imem_ready = 0;
    step();
    check("arst_no_held_word", 32'(out_valid), 32'h0);
    imem_ready = 1;
    step();
    check("arst_refetch", out_instruction, 32'h1000_0000);
    check("arst_refetch_pc", out_pc_added, 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
